// File: rtl/axi_xbar_pkg.sv
// Shared types and default widths for the AXI crossbar slave-side blocks.
package axi_xbar_pkg;

    // W-channel scheduler state: quiet, or routing the selected master.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } wch_state_e;

    // Default crossbar configuration.
    localparam int MST_NUM_DEF    = 4;
    localparam int AXI_DATA_W_DEF = 32;

    // Widths derived from the default configuration.
    localparam int MST_IDX_W = $clog2(MST_NUM_DEF);
    localparam int STRB_W    = AXI_DATA_W_DEF / 8;

endpackage

// File: rtl/axi_ord_fifo.sv
// Synchronous in-order FIFO with synchronous active-high reset.
// A push while full and a pop while empty are both ignored. dout is the
// head entry; dout_next is the entry behind it, valid when count > 1.
// DEPTH must be a power of 2 (>= 2) so the pointers wrap naturally.
module axi_ord_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [WIDTH-1:0]         dout_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign dout      = mem[rd_ptr];
    assign dout_next = mem[rd_ptr + PTR_W'(1)];
    assign count     = count_q;

    // Storage write.
    // NOTE: the storage array has no reset; an entry is only read after it has been written, so clearing it would cost reset fan-out for nothing.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axi_wch_arbiter.sv
// Slave-side W-channel scheduler. Records the master index of each AW
// granted to this slave and routes that master's W burst, in AW order and
// without interleaving, to the slave port until its wlast.
// Optional feature macro: WCH_WLAST_CHECK_EN -- stores awlen per entry,
// counts beats, forces slv_wlast from the count and pulses wlast_err when
// the master's wlast disagrees.
module axi_wch_arbiter
    import axi_xbar_pkg::*;
#(
    parameter int MST_NUM    = MST_NUM_DEF,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = AXI_DATA_W_DEF,
    parameter int OSTD_DEPTH = 4
) (
    input  logic                              aclk,
    input  logic                              srst,
    input  logic                              aw_push,
    input  logic [$clog2(MST_NUM)-1:0]        aw_mst,
    input  logic [7:0]                        aw_len,
    output logic                              aw_push_ready,
    input  logic [MST_NUM-1:0]                mst_wvalid,
    output logic [MST_NUM-1:0]                mst_wready,
    input  logic [MST_NUM-1:0]                mst_wlast,
    input  logic [MST_NUM*AXI_ID_W-1:0]       mst_wid,
    input  logic [MST_NUM*AXI_DATA_W-1:0]     mst_wdata,
    input  logic [MST_NUM*(AXI_DATA_W/8)-1:0] mst_wstrb,
    output logic                              slv_wvalid,
    input  logic                              slv_wready,
    output logic                              slv_wlast,
    output logic [AXI_ID_W-1:0]               slv_wid,
    output logic [AXI_DATA_W-1:0]             slv_wdata,
    output logic [AXI_DATA_W/8-1:0]           slv_wstrb,
    output logic [$clog2(OSTD_DEPTH):0]       ostd_cnt,
    output logic                              wlast_err
);

    localparam int IDX_W = $clog2(MST_NUM);
    localparam int SB_W  = AXI_DATA_W / 8;
    localparam int CNT_W = $clog2(OSTD_DEPTH) + 1;
`ifdef WCH_WLAST_CHECK_EN
    localparam int ENT_W = IDX_W + 8;
`else
    localparam int ENT_W = IDX_W;
`endif

    wch_state_e       state_q;
    wch_state_e       state_d;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] sel_d;
    logic [ENT_W-1:0] push_ent;
    logic [ENT_W-1:0] head_ent;
    logic [ENT_W-1:0] next_ent;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CNT_W-1:0] fifo_cnt;
    logic             sel_wlast;
    logic             beat_acc;

    axi_ord_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (OSTD_DEPTH)
    ) u_ord_fifo (
        .aclk      (aclk),
        .srst      (srst),
        .push      (aw_push),
        .din       (push_ent),
        .pop       (fifo_pop),
        .dout      (head_ent),
        .dout_next (next_ent),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign aw_push_ready = !fifo_full;
    assign ostd_cnt      = fifo_cnt;

    // Route the selected master to the slave port; everything quiet in IDLE.
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        slv_wvalid = 1'b0;
        mst_wready = '0;
        sel_wlast  = 1'b0;
        slv_wid    = '0;
        slv_wdata  = '0;
        slv_wstrb  = '0;
        if (state_q == ACTIVE) begin
            slv_wvalid        = mst_wvalid[sel_q];
            mst_wready[sel_q] = slv_wready;
            sel_wlast         = mst_wlast[sel_q];
            slv_wid           = mst_wid[int'(sel_q)*AXI_ID_W +: AXI_ID_W];
            slv_wdata         = mst_wdata[int'(sel_q)*AXI_DATA_W +: AXI_DATA_W];
            slv_wstrb         = mst_wstrb[int'(sel_q)*SB_W +: SB_W];
        end
    end

    assign beat_acc = slv_wvalid && slv_wready;
    assign fifo_pop = beat_acc && slv_wlast;

`ifdef WCH_WLAST_CHECK_EN
    logic [7:0] beat_cnt_q;
    logic [7:0] head_len;
    logic       exp_last;
    logic       wlast_err_q;
    logic       unused_next_len;

    assign push_ent        = {aw_len, aw_mst};
    assign head_len        = head_ent[ENT_W-1 -: 8];
    assign exp_last        = (beat_cnt_q == head_len);
    assign slv_wlast       = (state_q == ACTIVE) && exp_last;
    assign wlast_err       = wlast_err_q;
    assign unused_next_len = ^next_ent[ENT_W-1 -: 8];

    // Count beats of the current burst and flag a master wlast that disagrees with awlen.
    always_ff @(posedge aclk) begin
        if (srst) begin
            beat_cnt_q  <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            wlast_err_q <= beat_acc && (sel_wlast != exp_last);
            if (fifo_pop) begin
                beat_cnt_q <= '0;
            end else if (beat_acc) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
            end
        end
    end
`else
    logic unused_len;

    assign push_ent   = aw_mst;
    assign slv_wlast  = sel_wlast;
    assign wlast_err  = 1'b0;
    assign unused_len = ^aw_len;
`endif

    // Next-state: load the FIFO head from IDLE, chain straight into the next burst when one is queued.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ACTIVE;
                    sel_d   = head_ent[IDX_W-1:0];
                end
            end
            ACTIVE: begin
                if (fifo_pop) begin
                    if (fifo_cnt > CNT_W'(1)) begin
                        sel_d = next_ent[IDX_W-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and selected-master registers.
    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_axi_wch_arbiter.sv
// Self-checking bench for axi_wch_arbiter. A transaction-level model keeps
// the queue of recorded bursts and the expected W beat stream; a burst is
// routable from max(push cycle + 2, previous burst's last beat + 1).
module tb_axi_wch_arbiter;
    import axi_xbar_pkg::*;

    localparam int MST_NUM    = 4;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_DATA_W = 32;
    localparam int OSTD_DEPTH = 4;
    localparam int CNT_W      = $clog2(OSTD_DEPTH) + 1;

    logic                          aclk;
    logic                          srst;
    logic                          aw_push;
    logic [MST_IDX_W-1:0]          aw_mst;
    logic [7:0]                    aw_len;
    logic                          aw_push_ready;
    logic [MST_NUM-1:0]            mst_wvalid;
    logic [MST_NUM-1:0]            mst_wready;
    logic [MST_NUM-1:0]            mst_wlast;
    logic [MST_NUM*AXI_ID_W-1:0]   mst_wid;
    logic [MST_NUM*AXI_DATA_W-1:0] mst_wdata;
    logic [MST_NUM*STRB_W-1:0]     mst_wstrb;
    logic                          slv_wvalid;
    logic                          slv_wready;
    logic                          slv_wlast;
    logic [AXI_ID_W-1:0]           slv_wid;
    logic [AXI_DATA_W-1:0]         slv_wdata;
    logic [STRB_W-1:0]             slv_wstrb;
    logic [CNT_W-1:0]              ostd_cnt;
    logic                          wlast_err;

    axi_wch_arbiter #(
        .MST_NUM    (MST_NUM),
        .AXI_ID_W   (AXI_ID_W),
        .AXI_DATA_W (AXI_DATA_W),
        .OSTD_DEPTH (OSTD_DEPTH)
    ) dut (
        .aclk          (aclk),
        .srst          (srst),
        .aw_push       (aw_push),
        .aw_mst        (aw_mst),
        .aw_len        (aw_len),
        .aw_push_ready (aw_push_ready),
        .mst_wvalid    (mst_wvalid),
        .mst_wready    (mst_wready),
        .mst_wlast     (mst_wlast),
        .mst_wid       (mst_wid),
        .mst_wdata     (mst_wdata),
        .mst_wstrb     (mst_wstrb),
        .slv_wvalid    (slv_wvalid),
        .slv_wready    (slv_wready),
        .slv_wlast     (slv_wlast),
        .slv_wid       (slv_wid),
        .slv_wdata     (slv_wdata),
        .slv_wstrb     (slv_wstrb),
        .ostd_cnt      (ostd_cnt),
        .wlast_err     (wlast_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int                    mst;
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [STRB_W-1:0]     strb;
        bit                    last;
        bit                    bad;
    } beat_t;

    typedef struct {
        int mst;
        int push_cyc;
    } burst_t;

    beat_t  exp_q[$];
    burst_t bq[$];
    bit     hold [MST_NUM];
    int     cyc        = 0;
    int     last_end   = -10;
    bit     err_pend   = 1'b0;
    bit     acc_now    = 1'b0;
    int     n_acc      = 0;
    int     n_err      = 0;
    int     first_valid = -1;
    int     bad_idx    = -1;
    int     pv         = 100;
    int     rdy_mode   = 0;
    int     n_tests    = 0;
    int     n_fail     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int find_beat(input int m);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].mst == m) return i;
        end
        return -1;
    endfunction

    // Each master presents its oldest outstanding beat, holding it until accepted.
    task automatic drive_masters();
        for (int m = 0; m < MST_NUM; m++) begin
            int k = find_beat(m);
            if (k >= 0 && (hold[m] || $urandom_range(99) < pv)) begin
                hold[m]                                 = 1'b1;
                mst_wvalid[m]                           = 1'b1;
                mst_wlast[m]                            = exp_q[k].last ^ exp_q[k].bad;
                mst_wid[m*AXI_ID_W +: AXI_ID_W]         = exp_q[k].id;
                mst_wdata[m*AXI_DATA_W +: AXI_DATA_W]   = exp_q[k].data;
                mst_wstrb[m*STRB_W +: STRB_W]           = exp_q[k].strb;
            end else begin
                mst_wvalid[m]                           = 1'b0;
                mst_wlast[m]                            = 1'($urandom);
                mst_wid[m*AXI_ID_W +: AXI_ID_W]         = AXI_ID_W'($urandom);
                mst_wdata[m*AXI_DATA_W +: AXI_DATA_W]   = $urandom;
                mst_wstrb[m*STRB_W +: STRB_W]           = STRB_W'($urandom);
            end
        end
    endtask

    task automatic check_outputs();
        bit                 act;
        bit                 exp_valid;
        int                 st;
        int                 hm;
        logic [MST_NUM-1:0] exp_rdy;
        act       = 1'b0;
        exp_valid = 1'b0;
        exp_rdy   = '0;
        if (bq.size() > 0) begin
            st = bq[0].push_cyc + 2;
            if (last_end + 1 > st) st = last_end + 1;
            act = (cyc >= st);
        end
        if (act) begin
            hm          = bq[0].mst;
            exp_rdy[hm] = slv_wready;
            exp_valid   = mst_wvalid[hm];
        end
        check("slv_wvalid", slv_wvalid, exp_valid);
        check("mst_wready", mst_wready, exp_rdy);
        if (exp_valid) begin
            check("slv_wdata", slv_wdata, exp_q[0].data);
            check("slv_wid", slv_wid, exp_q[0].id);
            check("slv_wstrb", slv_wstrb, exp_q[0].strb);
            check("slv_wlast", slv_wlast, exp_q[0].last);
        end
        check("ostd_cnt", ostd_cnt, bq.size());
        check("aw_push_ready", aw_push_ready, bq.size() != OSTD_DEPTH);
        check("wlast_err", wlast_err, err_pend);
        if (slv_wvalid && first_valid < 0) first_valid = cyc;
        if (wlast_err) n_err++;
        acc_now = exp_valid && slv_wready;
    endtask

    task automatic update_model();
        beat_t b;
        bit    full_before;
        logic [AXI_ID_W-1:0] id;
        if (srst) begin
            exp_q.delete();
            bq.delete();
            for (int m = 0; m < MST_NUM; m++) hold[m] = 1'b0;
            last_end = -10;
            err_pend = 1'b0;
            return;
        end
        full_before = (bq.size() == OSTD_DEPTH);
        err_pend    = 1'b0;
        if (acc_now) begin
            b = exp_q.pop_front();
            hold[b.mst] = 1'b0;
`ifdef WCH_WLAST_CHECK_EN
            err_pend = b.bad;
`endif
            if (b.last) begin
                void'(bq.pop_front());
                last_end = cyc;
            end
            n_acc++;
        end
        if (aw_push && !full_before) begin
            bq.push_back('{mst: int'(aw_mst), push_cyc: cyc});
            id = AXI_ID_W'($urandom);
            for (int i = 0; i <= int'(aw_len); i++) begin
                b.mst  = int'(aw_mst);
                b.id   = id;
                b.data = $urandom;
                b.strb = STRB_W'($urandom);
                b.last = (i == int'(aw_len));
                b.bad  = (i == bad_idx);
                exp_q.push_back(b);
            end
            bad_idx = -1;
        end
    endtask

    task automatic step();
        case (rdy_mode)
            0:       slv_wready = 1'b1;
            1:       slv_wready = (cyc % 2 == 0);
            default: slv_wready = ($urandom_range(99) < 70);
        endcase
        drive_masters();
        @(negedge aclk);
        check_outputs();
        @(posedge aclk);
        update_model();
        #1;
        aw_push = 1'b0;
        cyc++;
    endtask

    task automatic push_aw(input int m, input int len);
        aw_push = 1'b1;
        aw_mst  = m[MST_IDX_W-1:0];
        aw_len  = len[7:0];
    endtask

    task automatic drain(input int budget);
        int b = budget;
        while (bq.size() > 0 && b > 0) begin
            step();
            b--;
        end
        check("drain_timeout", bq.size(), 0);
        repeat (2) step();
    endtask

    task automatic do_reset();
        srst = 1'b1;
        repeat (2) step();
        srst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int pc;
        srst       = 1'b1;
        aw_push    = 1'b0;
        aw_mst     = '0;
        aw_len     = '0;
        slv_wready = 1'b0;
        mst_wvalid = '0;
        mst_wlast  = '0;
        mst_wid    = '0;
        mst_wdata  = '0;
        mst_wstrb  = '0;
        for (int m = 0; m < MST_NUM; m++) hold[m] = 1'b0;
        do_reset();
        step();

        // Single burst: master 2, len 3.
        pv = 100; rdy_mode = 0;
        base = n_acc; first_valid = -1; pc = cyc;
        push_aw(2, 3);
        step();
        drain(20);
        check("single_latency", first_valid - pc, 2);
        check("single_beats", n_acc - base, 4);

        // Ordering: masters 1, 3, 0 pushed back to back, all masters valid.
        push_aw(1, 2); step();
        push_aw(3, 1); step();
        push_aw(0, 3); step();
        drain(40);

        // Backpressure: slave ready toggles during a len 7 burst.
        rdy_mode = 1; base = n_acc;
        push_aw(3, 7); step();
        drain(40);
        check("bp_beats", n_acc - base, 8);
        rdy_mode = 0;

        // Full order FIFO with no W traffic; a 5th push is ignored.
        pv = 0;
        for (int m = 0; m < 4; m++) begin
            push_aw(m, 1);
            step();
        end
        push_aw(1, 5); step();
        check("full_cnt", ostd_cnt, 4);
        check("full_ready", aw_push_ready, 1'b0);
        pv = 100;
        begin
            int b = 30;
            while (bq.size() == OSTD_DEPTH && b > 0) begin step(); b--; end
        end
        check("after_pop_ready", aw_push_ready, 1'b1);
        check("after_pop_cnt", ostd_cnt, 3);
        drain(60);

        // Reset in the middle of a burst, then a fresh burst.
        base = n_acc;
        push_aw(1, 3); step();
        begin
            int b = 20;
            while (n_acc - base < 2 && b > 0) begin step(); b--; end
        end
        check("rst_mid_beats", n_acc - base, 2);
        do_reset();
        check("rst_cnt", ostd_cnt, 0);
        check("rst_wready", mst_wready, '0);
        push_aw(2, 2); step();
        drain(30);

`ifdef WCH_WLAST_CHECK_EN
        // Early wlast on beat 2 of a len 3 burst.
        n_err = 0; base = n_acc;
        bad_idx = 1;
        push_aw(0, 3); step();
        drain(30);
        check("err_pulses", n_err, 1);
        check("err_beats", n_acc - base, 4);
`endif

        // Randomized traffic.
        pv = 70; rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if (bq.size() < OSTD_DEPTH && $urandom_range(99) < 30) begin
                push_aw($urandom_range(MST_NUM - 1), $urandom_range(7));
            end
            step();
        end
        pv = 100; rdy_mode = 0;
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
